// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared states, phase lengths and width helpers for the conv layer controller
//
// Purpose: common definitions for conv_layer_ctrl and the address generators.
// Ports:   none (package).
// Note:    flat_len() takes the pooling switch as an argument; the top feeds it
//          from the CONV_LAYER_CTRL_POOL_EN macro.
package conv_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_CONV    = 4'd2,
    ST_WR_CONV = 4'd3,
    ST_ROW_CHK = 4'd4,
    ST_KER_CHK = 4'd5,
    ST_POOL_RD = 4'd6,
    ST_POOL_WR = 4'd7,
    ST_FLAT    = 4'd8,
    ST_DONE    = 4'd9
  } conv_state_e;

  // Three input rows per output row, plus the read pipeline drain.
  function automatic int fetch_len(input int img_w, input int read_lat);
    return 3 * img_w + read_lat;
  endfunction

  // Whole conv map read for one kernel, plus the read pipeline drain.
  function automatic int pool_len(input int img_w, input int img_h, input int read_lat);
    return img_w * img_h + read_lat;
  endfunction

  // One pooled word per 2x2 window.
  function automatic int pool_wr_len(input int img_w, input int img_h);
    return (img_w / 2) * (img_h / 2);
  endfunction

  function automatic int flat_len(input int num_kernel, input int img_w, input int img_h,
                                  input bit pool_en);
    return pool_en ? num_kernel * (img_w / 2) * (img_h / 2) : num_kernel * img_w * img_h;
  endfunction

  function automatic int cnt_w(input int num_kernel, input int img_w, input int img_h,
                               input int read_lat);
    return $clog2(num_kernel * img_w * img_h + read_lat + 1);
  endfunction

  function automatic int row_w(input int img_h);
    return $clog2(img_h);
  endfunction

  function automatic int ker_w(input int num_kernel);
    return (num_kernel > 1) ? $clog2(num_kernel) : 1;
  endfunction

endpackage

// File: rtl/conv_phase_cnt.sv
// rtl/conv_phase_cnt.sv - terminal-count counter with hold and clear
//
// Purpose: up-counter reporting when it sits on a loadable terminal value.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   hold_i       freezes the count (highest priority after reset)
//   clr_i        returns the count to 0 (beats inc_i)
//   inc_i        advances the count by one
//   last_i       terminal value compared against the current count
//   cnt_o        current count
//   at_last_o    cnt_o == last_i
module conv_phase_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] last_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             at_last_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!hold_i) begin
      if (clr_i) begin
        cnt_d = '0;
      end else if (inc_i) begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign at_last_o = (cnt_q == last_i);

endmodule

// File: rtl/conv_layer_ctrl.sv
// rtl/conv_layer_ctrl.sv - sequencing controller for conv, ReLU, max-pool and flatten
//
// Purpose: walks rows and kernels through fetch/conv/write, then pooling and
//          flatten, driving one-cycle-granular enables to the datapath.
// Config:  CONV_LAYER_CTRL_POOL_EN builds the POOL_RD/POOL_WR stage; without it
//          the last kernel goes straight to FLAT over the full-size maps.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   start              run request, sampled only in IDLE
//   stall              holds state and counters, forces enables low
//   busy, done         run in progress / one-cycle completion pulse
//   fetch_en .. flat_en  per-phase enables (state decode, masked by stall)
//   local_idx, row_idx, ker_idx  phase, row and kernel counters
module conv_layer_ctrl
  import conv_pkg::*;
#(
  parameter  int IMG_W      = 64,
  parameter  int IMG_H      = 64,
  parameter  int NUM_KERNEL = 2,
  parameter  int READ_LAT   = 1,
  localparam int CNT_W      = cnt_w(NUM_KERNEL, IMG_W, IMG_H, READ_LAT),
  localparam int ROW_W      = row_w(IMG_H),
  localparam int KER_W      = ker_w(NUM_KERNEL)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic             fetch_en,
  output logic             conv_en,
  output logic             wr_conv_en,
  output logic             pool_rd_en,
  output logic             pool_wr_en,
  output logic             flat_en,
  output logic [CNT_W-1:0] local_idx,
  output logic [ROW_W-1:0] row_idx,
  output logic [KER_W-1:0] ker_idx
);

`ifdef CONV_LAYER_CTRL_POOL_EN
  localparam bit POOL_EN = 1'b1;
  localparam logic [CNT_W-1:0] LAST_POOL_RD = CNT_W'(pool_len(IMG_W, IMG_H, READ_LAT) - 1);
  localparam logic [CNT_W-1:0] LAST_POOL_WR = CNT_W'(pool_wr_len(IMG_W, IMG_H) - 1);
  localparam logic [CNT_W-1:0] POOL_RD_ON   = CNT_W'(IMG_W * IMG_H);
`else
  localparam bit POOL_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] LAST_FETCH = CNT_W'(fetch_len(IMG_W, READ_LAT) - 1);
  localparam logic [CNT_W-1:0] LAST_LINE  = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] LAST_FLAT  = CNT_W'(flat_len(NUM_KERNEL, IMG_W, IMG_H, POOL_EN) - 1);
  // Reads are issued for the first 3*IMG_W cycles; the tail only drains latency.
  localparam logic [CNT_W-1:0] FETCH_ON   = CNT_W'(3 * IMG_W);

  conv_state_e state_q, state_d;

  logic [CNT_W-1:0] phase_last;
  logic             local_clr, local_hold, local_tc;
  logic             row_step, row_tc;
  logic             ker_step, ker_tc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Terminal local_idx value for the current phase.
  always_comb begin
    phase_last = '0;
    case (state_q)
      ST_FETCH:            phase_last = LAST_FETCH;
      ST_CONV, ST_WR_CONV: phase_last = LAST_LINE;
`ifdef CONV_LAYER_CTRL_POOL_EN
      ST_POOL_RD:          phase_last = LAST_POOL_RD;
      ST_POOL_WR:          phase_last = LAST_POOL_WR;
`endif
      ST_FLAT:             phase_last = LAST_FLAT;
      default:             phase_last = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    busy       = 1'b1;
    done       = 1'b0;
    fetch_en   = 1'b0;
    conv_en    = 1'b0;
    wr_conv_en = 1'b0;
    pool_rd_en = 1'b0;
    pool_wr_en = 1'b0;
    flat_en    = 1'b0;
    row_step   = 1'b0;
    ker_step   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        fetch_en = (local_idx < FETCH_ON);
        if (local_tc) state_d = ST_CONV;
      end
      ST_CONV: begin
        conv_en = 1'b1;
        if (local_tc) state_d = ST_WR_CONV;
      end
      ST_WR_CONV: begin
        wr_conv_en = 1'b1;
        if (local_tc) state_d = ST_ROW_CHK;
      end
      ST_ROW_CHK: begin
        row_step = 1'b1;
        state_d  = row_tc ? ST_KER_CHK : ST_FETCH;
      end
      ST_KER_CHK: begin
        ker_step = 1'b1;
`ifdef CONV_LAYER_CTRL_POOL_EN
        state_d  = ker_tc ? ST_POOL_RD : ST_FETCH;
`else
        state_d  = ker_tc ? ST_FLAT : ST_FETCH;
`endif
      end
`ifdef CONV_LAYER_CTRL_POOL_EN
      ST_POOL_RD: begin
        pool_rd_en = (local_idx < POOL_RD_ON);
        if (local_tc) state_d = ST_POOL_WR;
      end
      ST_POOL_WR: begin
        pool_wr_en = 1'b1;
        if (local_tc) begin
          ker_step = 1'b1;
          state_d  = ker_tc ? ST_FLAT : ST_POOL_RD;
        end
      end
`endif
      ST_FLAT: begin
        flat_en = 1'b1;
        if (local_tc) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Stall freezes everything except start acceptance in IDLE.
    if (stall && (state_q != ST_IDLE)) begin
      state_d    = state_q;
      done       = 1'b0;
      fetch_en   = 1'b0;
      conv_en    = 1'b0;
      wr_conv_en = 1'b0;
      pool_rd_en = 1'b0;
      pool_wr_en = 1'b0;
      flat_en    = 1'b0;
      row_step   = 1'b0;
      ker_step   = 1'b0;
    end
  end

  // local_idx restarts on every state change; parked at 0 while idle.
  assign local_hold = stall && (state_q != ST_IDLE);
  assign local_clr  = (state_d != state_q) || (state_q == ST_IDLE);

  conv_phase_cnt #(.WIDTH(CNT_W)) u_local_cnt (
    .clk       (clk),
    .reset     (reset),
    .hold_i    (local_hold),
    .clr_i     (local_clr),
    .inc_i     (1'b1),
    .last_i    (phase_last),
    .cnt_o     (local_idx),
    .at_last_o (local_tc)
  );

  // Row and kernel counters wrap to 0 on their last value so every run and
  // the following phase start from index 0.
  conv_phase_cnt #(.WIDTH(ROW_W)) u_row_cnt (
    .clk       (clk),
    .reset     (reset),
    .hold_i    (stall),
    .clr_i     (row_step && row_tc),
    .inc_i     (row_step),
    .last_i    (ROW_W'(IMG_H - 1)),
    .cnt_o     (row_idx),
    .at_last_o (row_tc)
  );

  conv_phase_cnt #(.WIDTH(KER_W)) u_ker_cnt (
    .clk       (clk),
    .reset     (reset),
    .hold_i    (stall),
    .clr_i     (ker_step && ker_tc),
    .inc_i     (ker_step),
    .last_i    (KER_W'(NUM_KERNEL - 1)),
    .cnt_o     (ker_idx),
    .at_last_o (ker_tc)
  );

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// tb/tb_conv_layer_ctrl.sv - directed self-checking bench for conv_layer_ctrl
module tb_conv_layer_ctrl;

`ifdef CONV_LAYER_CTRL_POOL_EN
  localparam int RUN_LEN   = 229;
  localparam int EXP_PRD   = 32;
  localparam int EXP_PWR   = 8;
  localparam int EXP_FLAT  = 8;
  localparam int ABORT_AT  = 218;
  localparam int ABORT_KER = 1;
`else
  localparam int RUN_LEN   = 211;
  localparam int EXP_PRD   = 0;
  localparam int EXP_PWR   = 0;
  localparam int EXP_FLAT  = 32;
  localparam int ABORT_AT  = 190;
  localparam int ABORT_KER = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       busy, done, fetch_en, conv_en, wr_conv_en, pool_rd_en, pool_wr_en, flat_en;
  logic [5:0] local_idx;
  logic [1:0] row_idx;
  logic [0:0] ker_idx;

  conv_layer_ctrl #(
    .IMG_W      (4),
    .IMG_H      (4),
    .NUM_KERNEL (2),
    .READ_LAT   (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stall      (stall),
    .busy       (busy),
    .done       (done),
    .fetch_en   (fetch_en),
    .conv_en    (conv_en),
    .wr_conv_en (wr_conv_en),
    .pool_rd_en (pool_rd_en),
    .pool_wr_en (pool_wr_en),
    .flat_en    (flat_en),
    .local_idx  (local_idx),
    .row_idx    (row_idx),
    .ker_idx    (ker_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] all_outs();
    return {busy, done, fetch_en, conv_en, wr_conv_en, pool_rd_en, pool_wr_en, flat_en,
            local_idx, row_idx, ker_idx};
  endfunction

  int run_len, done_cnt, done_at;
  int fetch_c, conv_c, wr_c, prd_c, pwr_c, flat_c;
  int stall_bad, stall_local;
  int snap36_row, snap36_local, snap36_conv;
  int snap100_ker, snap100_local, snap100_fetch;

  // Called at a negedge with the DUT idle. n = 0 is the start cycle; n >= 1
  // are busy cycles. Stall is high for n in [stall_from, stall_from+stall_len).
  task automatic do_run(input int stall_from, input int stall_len, input bit pulses);
    int n;
    n = 0;
    run_len = 0; done_cnt = 0; done_at = 0;
    fetch_c = 0; conv_c = 0; wr_c = 0; prd_c = 0; pwr_c = 0; flat_c = 0;
    stall_bad = 0; stall_local = -1;
    snap36_row = -1; snap36_local = -1; snap36_conv = -1;
    snap100_ker = -1; snap100_local = -1; snap100_fetch = -1;
    while (n < 2000) begin
      stall = (n >= stall_from) && (n < stall_from + stall_len);
      start = (n == 0) || (pulses && (n == 5 || n == 50 || n == 150));
      #1;
      if (n > 0) begin
        if (!busy) break;
        run_len++;
        fetch_c += int'(fetch_en);
        conv_c  += int'(conv_en);
        wr_c    += int'(wr_conv_en);
        prd_c   += int'(pool_rd_en);
        pwr_c   += int'(pool_wr_en);
        flat_c  += int'(flat_en);
        if (done) begin
          done_cnt++;
          done_at = n;
        end
        if (stall) begin
          if (stall_local < 0) stall_local = int'(local_idx);
          if ({done, fetch_en, conv_en, wr_conv_en, pool_rd_en, pool_wr_en, flat_en} != 7'd0)
            stall_bad++;
          if (int'(local_idx) != stall_local) stall_bad++;
        end
        if (n == 36) begin
          snap36_row = int'(row_idx); snap36_local = int'(local_idx); snap36_conv = int'(conv_en);
        end
        if (n == 100) begin
          snap100_ker = int'(ker_idx); snap100_local = int'(local_idx); snap100_fetch = int'(fetch_en);
        end
      end
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("run_timeout", n, 0);
    stall = 1'b0;
    start = 1'b0;
  endtask

  int dpos[$];
  int w;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("in_reset_outs", all_outs(), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_reset_outs", all_outs(), 0);
    @(negedge clk);

    // Plain run
    do_run(100000, 0, 1'b0);
    check("run_len", run_len, RUN_LEN);
    check("done_cnt", done_cnt, 1);
    check("done_at", done_at, RUN_LEN);
    check("fetch_cnt", fetch_c, 96);
    check("conv_cnt", conv_c, 32);
    check("wr_conv_cnt", wr_c, 32);
    check("pool_rd_cnt", prd_c, EXP_PRD);
    check("pool_wr_cnt", pwr_c, EXP_PWR);
    check("flat_cnt", flat_c, EXP_FLAT);
    check("row1_conv_row", snap36_row, 1);
    check("row1_conv_local", snap36_local, 0);
    check("row1_conv_en", snap36_conv, 1);
    check("ker1_fetch_ker", snap100_ker, 1);
    check("ker1_fetch_local", snap100_local, 10);
    check("ker1_fetch_en", snap100_fetch, 1);
    repeat (3) @(negedge clk);
    #1;
    check("idle_after_run", all_outs(), 0);
    @(negedge clk);

    // Stall for 5 cycles in row 0 CONV (busy cycles 14..17 are CONV)
    do_run(15, 5, 1'b0);
    check("stall_run_len", run_len, RUN_LEN + 5);
    check("stall_quiet", stall_bad, 0);
    check("stall_local", stall_local, 1);
    check("stall_conv_cnt", conv_c, 32);
    check("stall_done_cnt", done_cnt, 1);
    @(negedge clk);

    // Stall already high when start is sampled in IDLE, held one busy cycle
    do_run(0, 2, 1'b0);
    check("idle_stall_run_len", run_len, RUN_LEN + 1);
    check("idle_stall_fetch", fetch_c, 96);
    check("idle_stall_quiet", stall_bad, 0);
    @(negedge clk);

    // start pulses while busy are ignored
    do_run(100000, 0, 1'b1);
    check("pulse_run_len", run_len, RUN_LEN);
    check("pulse_done_cnt", done_cnt, 1);
    repeat (2) @(negedge clk);
    #1;
    check("pulse_idle_busy", busy, 0);
    @(negedge clk);

    // Asynchronous reset late in the run
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < ABORT_AT; i++) @(negedge clk);
    #1;
`ifdef CONV_LAYER_CTRL_POOL_EN
    check("abort_phase_en", pool_wr_en, 1);
`else
    check("abort_phase_en", flat_en, 1);
`endif
    check("abort_ker", ker_idx, ABORT_KER);
    reset = 1'b1;
    #1;
    check("abort_outs", all_outs(), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_release_outs", all_outs(), 0);
    @(negedge clk);
    do_run(100000, 0, 1'b0);
    check("after_abort_run_len", run_len, RUN_LEN);
    check("after_abort_done_at", done_at, RUN_LEN);
    @(negedge clk);

    // start held high: back-to-back runs with one IDLE cycle between
    start = 1'b1;
    for (int c = 0; c < 700; c++) begin
      #1;
      if (done) dpos.push_back(c);
      @(negedge clk);
    end
    start = 1'b0;
    check("b2b_done_cnt", dpos.size(), 3);
    if (dpos.size() == 3) begin
      check("b2b_first", dpos[0], RUN_LEN);
      check("b2b_gap1", dpos[1] - dpos[0], RUN_LEN + 1);
      check("b2b_gap2", dpos[2] - dpos[1], RUN_LEN + 1);
    end
    w = 0;
    #1;
    while (busy && w < 1000) begin
      @(negedge clk);
      #1;
      w++;
    end
    check("b2b_drain_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_layer_ctrl.md
Name: conv_layer_ctrl

Overview:
- Parametrised sequencing controller for the conv → ReLU → max-pool → flatten layer pipeline.
- Owns all phase counters internally: local index, row index, kernel index.
- Drives one-cycle-granular enable flags to the datapath/address generators.
- Supports any image size and any kernel count, a datapath stall input, restart after completion, and a compile-time optional pooling stage.

Parameters:
- IMG_W, 64, image width in pixels; even, ≥4.
- IMG_H, 64, image height in rows; even, ≥4.
- NUM_KERNEL, 2, number of conv kernels/output channels, ≥1.
- READ_LAT, 1, memory read latency in cycles, 0..3.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  level request; sampled only in IDLE
- stall  in  1  freezes FSM and counters while high
- busy  out  1  high from first cycle after start accepted through DONE
- done  out  1  one-cycle pulse in DONE
- fetch_en  out  1  input-window read enable
- conv_en  out  1  conv/ReLU compute enable
- wr_conv_en  out  1  conv result write enable
- pool_rd_en  out  1  conv map read enable for pooling
- pool_wr_en  out  1  pooled result write enable
- flat_en  out  1  flatten write enable
- local_idx  out  CNT_W  intra-phase counter
- row_idx  out  ROW_W  current conv row
- ker_idx  out  KER_W  current kernel

Behaviour:
- Widths:
  - CNT_W = clog2(NUM_KERNEL*IMG_W*IMG_H + READ_LAT + 1).
  - ROW_W = clog2(IMG_H).
  - KER_W = max(1, clog2(NUM_KERNEL)).
- Reset: state IDLE; all outputs 0; all counters 0.
- Reset mid-operation aborts immediately with the same values.
- Binary-encoded FSM, registered state. Every enable flag is a registered-state decode (Moore).
- local_idx counts 0,1,2,… in each state and clears to 0 on every state transition.
- States, transitions, and flags:
  - IDLE: busy=0. If start=1 → FETCH with row_idx=0, ker_idx=0.
  - FETCH: fetch_en=1 while local_idx < 3*IMG_W. After 3*IMG_W + READ_LAT cycles → CONV.
  - CONV: conv_en=1 for IMG_W cycles → WR_CONV.
  - WR_CONV: wr_conv_en=1 for IMG_W cycles → ROW_CHK.
  - ROW_CHK (1 cycle):
    - If row_idx == IMG_H-1: row_idx ← 0 → KER_CHK.
    - Else: row_idx++ → FETCH.
  - KER_CHK (1 cycle):
    - If ker_idx == NUM_KERNEL-1: ker_idx ← 0 → POOL_RD.
    - Else: ker_idx++ → FETCH.
  - POOL_RD: pool_rd_en=1 while local_idx < IMG_W*IMG_H. After IMG_W*IMG_H + READ_LAT cycles → POOL_WR.
  - POOL_WR: pool_wr_en=1 for (IMG_W/2)*(IMG_H/2) cycles.
    - If ker_idx == NUM_KERNEL-1: ker_idx ← 0 → FLAT.
    - Else: ker_idx++ → POOL_RD.
  - FLAT: flat_en=1 for NUM_KERNEL*(IMG_W/2)*(IMG_H/2) cycles → DONE.
  - DONE (1 cycle): done=1, busy=1 → IDLE.
- Stall:
  - While stall=1, state and all counters hold and all enables are 0.
  - The next transition occurs only on non-stalled cycles.
  - Stall in IDLE has no effect on start acceptance.
- start while busy is ignored. start held high through DONE starts a new run directly from IDLE (back-to-back).
- Simultaneous stall and terminal count: stall wins; the transition is deferred.

Optional Feature:
- Macro: CONV_LAYER_CTRL_POOL_EN.
- Defined: POOL_RD/POOL_WR present as above.
- Undefined:
  - Pool states are not built.
  - KER_CHK on the last kernel goes → FLAT.
  - FLAT lasts NUM_KERNEL*IMG_W*IMG_H cycles.
  - pool_rd_en and pool_wr_en are tied to 0.

Decomposition:
- Shared package conv_pkg:
  - State enum.
  - Phase-length constant functions (fetch_len, pool_len, flat_len).
  - Width helpers, shared with the address generators.
- One natural sub-module: conv_phase_cnt, a loadable terminal-count counter with hold (stall) and clear. The same sub-module is instantiated for local_idx, row_idx, and ker_idx.

Test Plan:
- All tests use IMG_W=IMG_H=4, NUM_KERNEL=2, READ_LAT=1, pool enabled.
- Reset, then start=1 one cycle → busy high for exactly 229 cycles; done pulses once on the last of them; then IDLE.
- Flag counts over one run:
  - fetch_en = 96 cycles.
  - conv_en = 32.
  - wr_conv_en = 32.
  - pool_rd_en = 32.
  - pool_wr_en = 8.
  - flat_en = 8.
- Assert stall for 5 cycles mid-CONV → all enables 0 during the stall, local_idx frozen, run length becomes 234 cycles.
- Assert reset during POOL_WR of kernel 1 → next cycle: all outputs 0, IDLE. A new start completes normally in 229 cycles.
- Pool disabled (macro undefined) → busy 211 cycles, flat_en 32 cycles, pool enables never high.
- start held high continuously → done pulses every 230 cycles; start pulses while busy have no effect.
